clock_monitor: RTL
==================

# clock_monitor

Receive-side companion to the front-panel clock divider. It samples a slow, divided clock (`clk_in`) in the fast `clk` domain and synchronises it. It produces a one-cycle rising-edge strobe for downstream enables, measures the period in `clk` cycles, and reports lock/loss status against an expected period. It sits between any divided-clock source and the front-panel logic that consumes slow-tick enables.

## Interface
Parameters:
- `WIDTH`, 8: width of the period counter and `period` output.
- `EXP_PERIOD`, 10: expected `clk_in` period in `clk` cycles.
- `TOL`, 1: allowed absolute deviation from `EXP_PERIOD` for a period to count as good.
- `LOCK_CNT`, 4: consecutive good periods required to lock. Range 1..15.
- `TIMEOUT`, 40: `clk` cycles without an edge before loss is declared. Must be < 2^WIDTH-1.

Ports:
- `clk`, input, 1: system clock; all logic on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `clk_in`, input, 1: divided clock under observation; asynchronous to `clk`.
- `rise_stb`, output, 1: one-cycle pulse per detected `clk_in` rising edge.
- `period`, output, WIDTH: last measured period in `clk` cycles.
- `period_vld`, output, 1: one-cycle pulse when `period` updates.
- `locked`, output, 1: high while in LOCK.
- `lost`, output, 1: high while in LOST.

## Operation
- Synchroniser and edge detect: `clk_in` passes through flops s1→s2, then s3. The internal `rise` is s2 & ~s3. `rise_stb` is `rise` registered.
- Period counter `cnt` (WIDTH bits, reset 0):
  - If `rise`, `cnt` ← 1.
  - Otherwise `cnt` ← `cnt`+1, saturating at 2^WIDTH-1 with no wrap.
  - Two rises P cycles apart yield `cnt`==P at the second rise.
- Measurement:
  - On `rise` with flag `seen`=1, `period` ← `cnt` and `period_vld` pulses.
  - The first rise after reset or after LOST only sets `seen`. It produces no `period_vld`.
- Good period: `EXP_PERIOD`-`TOL` ≤ `cnt` ≤ `EXP_PERIOD`+`TOL`, evaluated at `rise` with `seen`=1. A 4-bit `good_cnt` counts consecutive good periods.
- FSM (reset to IDLE):
  - IDLE → ACQ on `rise`, which sets `seen`.
  - IDLE → LOST when `cnt`==`TIMEOUT`, so a clock dead from power-up is reported.
  - ACQ:
    - Good period: `good_cnt`++. If the result equals `LOCK_CNT`, go to LOCK.
    - Bad period: `good_cnt` ← 0 and stay in ACQ.
    - `cnt`==`TIMEOUT` with no `rise`: go to LOST.
  - LOCK:
    - Good period: stay in LOCK.
    - Bad period: go to ACQ with `good_cnt` ← 0.
    - Timeout: go to LOST.
  - LOST:
    - Clears `seen` and `good_cnt`.
    - On `rise`, go to ACQ with `seen` ← 1. That edge gives no period.
- Simultaneous `rise` and `cnt`==`TIMEOUT`: `rise` wins and no timeout is taken.
- Reset mid-operation: every register returns to its reset value immediately (asynchronous). The FSM goes to IDLE and the synchroniser clears to 0.

## Timing
- Reset values: `rise_stb`=0, `period`=0, `period_vld`=0, `locked`=0, `lost`=0. Internally `cnt`=0, `seen`=0, `good_cnt`=0, s1/s2/s3=0.
- A `clk_in` high first captured by s1 at edge k gives `rise` during cycle k+1→k+2. `rise_stb` is high for the cycle after edge k+2, a latency of 3 `clk` edges.
- `period`, `period_vld`, `locked` and `lost` all update on the same edge that raises `rise_stb`. The exception is a timeout, which sets `lost` (and clears `locked`) on the edge after `cnt` reaches `TIMEOUT`.
- `locked` rises on the edge of the `LOCK_CNT`-th good `period_vld`. It falls on the edge of the first bad `period_vld` or on timeout.
- `clk_in` high and low phases must each be ≥ 2 `clk` cycles. Shorter pulses may be missed, and this is not flagged.

## Test plan
- Lock acquisition (defaults), `clk_in` period 10 `clk`:
  - First edge gives `rise_stb` with no `period_vld`.
  - The next 4 edges give `period`=10 with `period_vld`.
  - `locked`=1 on the 4th `period_vld`; `lost`=0 throughout.
- Tolerance edges:
  - Periods 9 and 11 stay locked.
  - A single period of 12 drops `locked` on that `period_vld` with `period`=12.
  - 4 more periods of 10 relock.
- Loss: stop `clk_in` while locked. Exactly 40 cycles after the last `rise`, `lost`=1 and `locked`=0. Resume `clk_in`: the first edge gives no `period_vld`, and lock returns after 4 good periods with `lost` falling on that first edge.
- Dead from reset: hold `clk_in`=0 after deasserting `rst_n`. `lost`=1 after 40 cycles, and `period` stays 0.
- Saturation: with WIDTH=6 and TIMEOUT=60, a `clk_in` period of 70 gives `lost`=1 at 60 cycles. No wrap: `cnt` holds at 63, and the following edge gives no `period_vld`.
- Async reset mid-lock: pulse `rst_n` low for half a `clk` cycle while locked. All outputs go to 0 immediately, before the next `clk` edge, and reacquisition takes 1+4 edges.

Source files
------------

// File: rtl/clock_monitor.sv
// Divided-clock monitor: synchronises clk_in, strobes its rising edges,
// measures the period in clk cycles and tracks lock/loss status.
module clock_monitor #(
  parameter int WIDTH      = 8,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic             rise_stb,
  output logic [WIDTH-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             lost
);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCK,
    LOST
  } state_t;

  localparam int LO_I = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam int HI_I = EXP_PERIOD + TOL;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] LO      = WIDTH'(LO_I);
  localparam logic [WIDTH-1:0] HI      = WIDTH'(HI_I);
  localparam logic [WIDTH-1:0] TMO     = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic             seen;
  logic             seen_nxt;
  logic [3:0]       good_cnt;
  logic [3:0]       good_nxt;
  logic [3:0]       good_inc;
  logic             meas;
  logic             good;
  logic             tmo;
  state_t           state;
  state_t           state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + ONE;
    end
  end

  // seen is cleared on entry to LOST, so any rise with seen set is a period
  assign meas     = rise & seen;
  assign good     = meas & (cnt >= LO) & (cnt <= HI);
  assign tmo      = ~rise & (cnt == TMO);
  assign good_inc = good_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = ACQ;
        end else if (tmo) begin
          state_nxt = LOST;
        end
      end
      ACQ: begin
        if (good && good_inc == LOCK_N) begin
          state_nxt = LOCK;
        end else if (tmo) begin
          state_nxt = LOST;
        end
      end
      LOCK: begin
        if (meas && !good) begin
          state_nxt = ACQ;
        end else if (tmo) begin
          state_nxt = LOST;
        end
      end
      LOST: begin
        if (rise) begin
          state_nxt = ACQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    good_nxt = good_cnt;
    seen_nxt = seen;
    unique case (1'b1)
      (state_nxt == LOST): begin
        good_nxt = 4'd0;
        seen_nxt = 1'b0;
      end
      rise: begin
        seen_nxt = 1'b1;
        if (good && state == ACQ) begin
          good_nxt = good_inc;
        end else if (!good) begin
          good_nxt = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= 4'd0;
      seen     <= 1'b0;
    end else begin
      good_cnt <= good_nxt;
      seen     <= seen_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_stb   <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      rise_stb   <= rise;
      period_vld <= meas;
      if (meas) begin
        period <= cnt;
      end
    end
  end

  always_comb begin
    locked = (state == LOCK);
    lost   = (state == LOST);
  end

endmodule
